// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and dmem_responder.
// req_be exists only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    output req_be,
`endif
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  req_be,
`endif
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory target: one word access per request, response after LATENCY cycles.
// Optional macro DMEM_BYTE_STROBE_EN adds per-byte store strobes (req_be).
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  be_q, be_d;
`endif

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  acc_err;
  logic                  access_now;
  logic                  mem_we;
  logic [31:0]           wr_word;

  assign idx        = addr_q[ADDR_WIDTH+1:2];
  assign acc_err    = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we     = access_now && we_q && !acc_err;

  // Strobed stores merge into the existing word; otherwise the whole word is replaced.
  always_comb begin
    wr_word = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    wr_word = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    be_d        = be_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
          be_d        = bus.req_be;
`endif
          cnt_d       = LAT_M1;
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 32'd0 : mem[idx];
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
      be_q        <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef DMEM_BYTE_STROBE_EN
      be_q        <= be_d;
`endif
    end
  end

  // Storage has no reset; a reset before the commit edge leaves state_q in IDLE, so no write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
